// File: rtl/serdes_sym_pkg.sv
// rtl/serdes_sym_pkg.sv - shared symbol-mapping constants and Gray helpers
package serdes_sym_pkg;

  localparam int MAX_BITS_PER_SYM = 8;

  // PAM4 level indices, lowest to highest eye level; Tx and Rx must agree
  localparam logic [1:0] PAM4_LVL_M3 = 2'd0;
  localparam logic [1:0] PAM4_LVL_M1 = 2'd1;
  localparam logic [1:0] PAM4_LVL_P1 = 2'd2;
  localparam logic [1:0] PAM4_LVL_P3 = 2'd3;

  function automatic logic [MAX_BITS_PER_SYM-1:0] bin2gray(
    input logic [MAX_BITS_PER_SYM-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_BITS_PER_SYM-1:0] gray2bin(
    input logic [MAX_BITS_PER_SYM-1:0] g
  );
    logic [MAX_BITS_PER_SYM-1:0] b;
    b[MAX_BITS_PER_SYM-1] = g[MAX_BITS_PER_SYM-1];
    for (int i = MAX_BITS_PER_SYM - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sym_out_slice.sv
// rtl/sym_out_slice.sv - single-entry valid/ready output register (load, hold, drain)
module sym_out_slice #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_free
);

  assign out_free = !out_valid || out_ready;

  // load has priority so a handoff and a new symbol can share one edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pam_gray_mapper.sv
// rtl/pam_gray_mapper.sv - serial bits to PAM-2^N symbols with Gray/binary map and flush
module pam_gray_mapper
  import serdes_sym_pkg::*;
#(
  parameter int BITS_PER_SYM = 2,
  parameter int MSB_FIRST    = 1,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  input  logic                    gray_en,
  output logic [BITS_PER_SYM-1:0] sym_out,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic [CNT_W-1:0]        sym_count
);

  localparam int CW = $clog2(BITS_PER_SYM + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS_PER_SYM - 1);

  logic [CW-1:0]               cnt;
  logic [BITS_PER_SYM-1:0]     shreg;
  logic                        flush_pend;

  logic                        out_free;
  logic                        flush_req;
  logic                        accept;
  logic                        complete;
  logic                        flush_svc;
  logic                        load;
  logic [BITS_PER_SYM-1:0]     shreg_in;
  logic [BITS_PER_SYM-1:0]     pad_word;
  logic [BITS_PER_SYM-1:0]     word;
  logic [BITS_PER_SYM-1:0]     mapped;
  logic [MAX_BITS_PER_SYM-1:0] word_ext;

  assign flush_req = flush || flush_pend;
  assign in_ready  = !flush_req && ((cnt != LAST) || out_free);
  assign accept    = in_valid && in_ready;
  assign complete  = accept && (cnt == LAST);
  assign flush_svc = flush_req && (cnt != '0) && out_free;
  assign load      = complete || flush_svc;

  always_comb begin
    shreg_in = shreg;
    if (MSB_FIRST != 0) begin
      shreg_in    = shreg << 1;
      shreg_in[0] = in_data;
    end else begin
      for (int i = 0; i < BITS_PER_SYM; i++) begin
        if (cnt == CW'(i)) shreg_in[i] = in_data;
      end
    end
  end

  // MSB-first partials are left-justified; LSB-first partials already sit low
  always_comb begin
    pad_word = shreg;
    if (MSB_FIRST != 0) pad_word = shreg << (CW'(BITS_PER_SYM) - cnt);
  end

  always_comb begin
    word     = complete ? shreg_in : pad_word;
    word_ext = MAX_BITS_PER_SYM'(word);
    mapped   = gray_en ? BITS_PER_SYM'(bin2gray(word_ext)) : word;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt        <= '0;
      shreg      <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (load) begin
        cnt   <= '0;
        shreg <= '0;
      end else if (accept) begin
        cnt   <= cnt + CW'(1);
        shreg <= shreg_in;
      end
      if (flush_req && ((cnt == '0) || flush_svc)) begin
        flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sym_count <= '0;
    end else if (sym_valid && sym_ready) begin
      sym_count <= sym_count + CNT_W'(1);
    end
  end

  sym_out_slice #(
    .W (BITS_PER_SYM)
  ) u_out (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .load_data (mapped),
    .out_ready (sym_ready),
    .out_data  (sym_out),
    .out_valid (sym_valid),
    .out_free  (out_free)
  );

endmodule

// File: tb/tb_pam_gray_mapper.sv
// tb/tb_pam_gray_mapper.sv - bench for PAM4/PAM8 MSB-first and PAM4 LSB-first mappers
module tb_pam_gray_mapper;

  logic clk;
  logic rstn, in_data, in_valid, flush, gray_en, sym_ready;
  logic ir0, ir1, ir2, sv0, sv1, sv2;
  logic [1:0] so0, so2;
  logic [2:0] so1;
  logic [31:0] sc0, sc1, sc2;

  int n_vec = 0;
  int n_bad = 0;

  localparam int BK [3] = '{2, 3, 2};
  localparam int MF [3] = '{1, 1, 0};

  pam_gray_mapper #(.BITS_PER_SYM(2), .MSB_FIRST(1), .CNT_W(32)) u_p4 (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
    .flush(flush), .gray_en(gray_en), .sym_out(so0), .sym_valid(sv0),
    .sym_ready(sym_ready), .sym_count(sc0));

  pam_gray_mapper #(.BITS_PER_SYM(3), .MSB_FIRST(1), .CNT_W(32)) u_p8 (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(ir1),
    .flush(flush), .gray_en(gray_en), .sym_out(so1), .sym_valid(sv1),
    .sym_ready(sym_ready), .sym_count(sc1));

  pam_gray_mapper #(.BITS_PER_SYM(2), .MSB_FIRST(0), .CNT_W(32)) u_p4l (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(ir2),
    .flush(flush), .gray_en(gray_en), .sym_out(so2), .sym_valid(sv2),
    .sym_ready(sym_ready), .sym_count(sc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, d, v, fl, g, rdy;
    logic chk_ir, exp_ir, exp_sv;
    logic [7:0] exp_so;
    logic [31:0] exp_sc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic d, logic v, logic fl, logic g, logic rdy,
                              logic chk_ir, logic exp_ir, logic exp_sv,
                              logic [7:0] exp_so, logic [31:0] exp_sc);
    vec_t r;
    r.rst = rst; r.d = d; r.v = v; r.fl = fl; r.g = g; r.rdy = rdy;
    r.chk_ir = chk_ir; r.exp_ir = exp_ir; r.exp_sv = exp_sv;
    r.exp_so = exp_so; r.exp_sc = exp_sc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic d, input logic v,
                       input logic fl, input logic g, input logic rdy);
    rstn = !rst; in_data = d; in_valid = v; flush = fl; gray_en = g; sym_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] act_ir(int k);
    case (k)
      0: return 32'(ir0);
      1: return 32'(ir1);
      default: return 32'(ir2);
    endcase
  endfunction

  function automatic logic [31:0] act_sv(int k);
    case (k)
      0: return 32'(sv0);
      1: return 32'(sv1);
      default: return 32'(sv2);
    endcase
  endfunction

  function automatic logic [31:0] act_so(int k);
    case (k)
      0: return 32'(so0);
      1: return 32'(so1);
      default: return 32'(so2);
    endcase
  endfunction

  function automatic logic [31:0] act_sc(int k);
    case (k)
      0: return sc0;
      1: return sc1;
      default: return sc2;
    endcase
  endfunction

  // Reference model: list of received bits, held symbol, pending flush, counter
  int          mb [3][8];
  int          mn [3];
  bit          mhv [3];
  bit          mfp [3];
  logic [7:0]  mout [3];
  logic [31:0] mcnt [3];

  function automatic logic [7:0] word_of(int k);
    int sum = 0;
    for (int i = 0; i < mn[k]; i++) begin
      if (MF[k] != 0) sum += mb[k][i] << (BK[k] - 1 - i);
      else            sum += mb[k][i] << i;
    end
    return 8'(sum);
  endfunction

  function automatic logic model_ir(int k, logic fl, logic rdy);
    bit free = !mhv[k] || rdy;
    return !(fl || mfp[k]) && ((mn[k] != BK[k] - 1) || free);
  endfunction

  task automatic model_step(input int k, input logic rst, input logic d, input logic v,
                            input logic fl, input logic g, input logic rdy);
    bit free, freq, ir, ho, ld;
    logic [7:0] w;
    if (rst) begin
      mn[k] = 0; mhv[k] = 0; mfp[k] = 0; mout[k] = 0; mcnt[k] = 0;
      return;
    end
    free = !mhv[k] || rdy;
    freq = fl || mfp[k];
    ir   = model_ir(k, fl, rdy);
    ho   = mhv[k] && rdy;
    ld   = 0;
    w    = 0;
    if (ir && v) begin
      mb[k][mn[k]] = int'(d);
      mn[k]++;
      if (mn[k] == BK[k]) begin
        w = word_of(k); mn[k] = 0; ld = 1;
      end
    end else if (freq) begin
      if (mn[k] == 0) mfp[k] = 0;
      else if (free) begin
        w = word_of(k); mn[k] = 0; mfp[k] = 0; ld = 1;
      end else if (fl) mfp[k] = 1;
    end
    if (ho) mcnt[k]++;
    if (ld) begin
      mhv[k] = 1;
      mout[k] = g ? (w ^ (w >> 1)) : w;
    end else if (ho) begin
      mhv[k] = 0;
    end
  endtask

  initial begin
    logic rst, d, v, fl, g, rdy;

    // PAM4 MSB-first: Gray stream, binary stream, backpressure, reset mid-symbol
    tbl.push_back(mk(1,0,0,0,1,1, 0,0, 0,8'd0,0));
    tbl.push_back(mk(0,0,1,0,1,1, 1,1, 0,8'd0,0));
    tbl.push_back(mk(0,0,1,0,1,1, 1,1, 1,8'd0,0));
    tbl.push_back(mk(0,0,1,0,1,1, 1,1, 0,8'd0,1));
    tbl.push_back(mk(0,1,1,0,1,1, 1,1, 1,8'd1,1));
    tbl.push_back(mk(0,1,1,0,1,1, 1,1, 0,8'd0,2));
    tbl.push_back(mk(0,1,1,0,1,1, 1,1, 1,8'd2,2));
    tbl.push_back(mk(0,1,1,0,1,1, 1,1, 0,8'd0,3));
    tbl.push_back(mk(0,0,1,0,1,1, 1,1, 1,8'd3,3));
    tbl.push_back(mk(0,0,0,0,1,1, 1,1, 0,8'd0,4));
    tbl.push_back(mk(0,0,1,0,0,1, 1,1, 0,8'd0,4));
    tbl.push_back(mk(0,0,1,0,0,1, 1,1, 1,8'd0,4));
    tbl.push_back(mk(0,0,1,0,0,1, 1,1, 0,8'd0,5));
    tbl.push_back(mk(0,1,1,0,0,1, 1,1, 1,8'd1,5));
    tbl.push_back(mk(0,1,1,0,0,1, 1,1, 0,8'd0,6));
    tbl.push_back(mk(0,1,1,0,0,1, 1,1, 1,8'd3,6));
    tbl.push_back(mk(0,1,1,0,0,1, 1,1, 0,8'd0,7));
    tbl.push_back(mk(0,0,1,0,0,1, 1,1, 1,8'd2,7));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1, 0,8'd0,8));
    tbl.push_back(mk(0,0,1,0,1,1, 1,1, 0,8'd0,8));
    tbl.push_back(mk(0,1,1,0,1,1, 1,1, 1,8'd1,8));
    tbl.push_back(mk(0,1,1,0,1,0, 1,1, 1,8'd1,8));
    tbl.push_back(mk(0,1,1,0,1,0, 1,0, 1,8'd1,8));
    tbl.push_back(mk(0,1,1,0,1,1, 1,1, 1,8'd2,9));
    tbl.push_back(mk(0,0,0,0,1,1, 1,1, 0,8'd0,10));
    tbl.push_back(mk(0,1,1,0,1,1, 1,1, 0,8'd0,10));
    tbl.push_back(mk(1,0,0,0,1,1, 1,1, 0,8'd0,0));
    tbl.push_back(mk(0,1,1,0,1,1, 1,1, 0,8'd0,0));
    tbl.push_back(mk(0,1,1,0,1,1, 1,1, 1,8'd2,0));
    tbl.push_back(mk(0,0,0,0,1,1, 1,1, 0,8'd0,1));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].d, tbl[i].v, tbl[i].fl, tbl[i].g, tbl[i].rdy);
      if (tbl[i].chk_ir) chk($sformatf("tbl%0d_in_ready", i), 32'(ir0), 32'(tbl[i].exp_ir));
      tick();
      chk($sformatf("tbl%0d_sym_valid", i), 32'(sv0), 32'(tbl[i].exp_sv));
      if (tbl[i].exp_sv || tbl[i].rst)
        chk($sformatf("tbl%0d_sym_out", i), 32'(so0), 32'(tbl[i].exp_so));
      chk($sformatf("tbl%0d_sym_count", i), sc0, tbl[i].exp_sc);
    end

    // PAM8 flush: partial, empty, and stalled-then-serviced
    apply(1,0,0,0,1,1); tick();
    apply(0,1,1,0,1,1); tick();
    apply(0,0,0,1,1,1); chk("p8_flush_in_ready", 32'(ir1), 0); tick();
    chk("p8_flush_valid", 32'(sv1), 1);
    chk("p8_flush_out", 32'(so1), 32'h6);
    chk("p8_flush_count0", sc1, 0);
    apply(0,0,0,0,1,1); tick();
    chk("p8_flush_drain", 32'(sv1), 0);
    chk("p8_flush_count1", sc1, 1);
    apply(0,0,0,1,1,1); tick();
    chk("p8_empty_flush_valid", 32'(sv1), 0);
    apply(0,0,0,0,1,1); tick();
    chk("p8_empty_flush_valid2", 32'(sv1), 0);
    chk("p8_empty_flush_count", sc1, 1);
    apply(0,1,1,0,1,0); tick();
    apply(0,0,1,0,1,0); tick();
    apply(0,1,1,0,1,0); tick();
    chk("p8_stall_valid", 32'(sv1), 1);
    chk("p8_stall_out", 32'(so1), 32'h7);
    apply(0,1,1,0,1,0); tick();
    apply(0,0,0,1,1,0); tick();
    chk("p8_pend_hold_out", 32'(so1), 32'h7);
    apply(0,1,1,0,1,0); chk("p8_pend_in_ready", 32'(ir1), 0); tick();
    chk("p8_pend_hold_count", sc1, 1);
    apply(0,0,0,0,1,1); chk("p8_pend_release_in_ready", 32'(ir1), 0); tick();
    chk("p8_pend_emit_valid", 32'(sv1), 1);
    chk("p8_pend_emit_out", 32'(so1), 32'h6);
    chk("p8_pend_emit_count", sc1, 2);
    apply(0,0,0,0,1,1); tick();
    chk("p8_pend_drain_valid", 32'(sv1), 0);
    chk("p8_pend_drain_count", sc1, 3);

    // PAM4 LSB-first ordering
    apply(1,0,0,0,1,1); tick();
    apply(0,1,1,0,1,1); tick();
    apply(0,0,1,0,1,1); tick();
    chk("lsb_sym1_valid", 32'(sv2), 1);
    chk("lsb_sym1_out", 32'(so2), 32'h1);
    apply(0,0,1,0,1,1); tick();
    apply(0,1,1,0,1,1); tick();
    chk("lsb_sym2_valid", 32'(sv2), 1);
    chk("lsb_sym2_out", 32'(so2), 32'h3);

    // Randomized run of all three instances against the model
    apply(1,0,0,0,1,1);
    for (int k = 0; k < 3; k++) model_step(k, 1, 0, 0, 0, 1, 1);
    tick();
    g = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      d   = 1'($urandom_range(0, 1));
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) g = !g;
      rdy = ($urandom_range(0, 3) != 0);
      apply(rst, d, v, fl, g, rdy);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rnd%0d_u%0d_in_ready", n, k), act_ir(k), 32'(model_ir(k, fl, rdy)));
        model_step(k, rst, d, v, fl, g, rdy);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rnd%0d_u%0d_sym_valid", n, k), act_sv(k), 32'(mhv[k]));
        if (mhv[k]) chk($sformatf("rnd%0d_u%0d_sym_out", n, k), act_so(k), 32'(mout[k]));
        chk($sformatf("rnd%0d_u%0d_sym_count", n, k), act_sc(k), mcnt[k]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pam_gray_mapper.md
Name: pam_gray_mapper

Overview:
Parametrised Tx serial-bit to PAM-N symbol mapper. Packs BITS_PER_SYM input bits into one symbol and applies a run-time selectable Gray or straight-binary mapping. Adds ready/valid backpressure, partial-symbol flush and a symbol counter. It sits between the PRBS/data source and the PAM level driver, and generalises the fixed 2-bit Gray encoder to any PAM-2^N order.

Parameters:
- BITS_PER_SYM, 2, bits per symbol (legal range 1..8); 2 = PAM4, 3 = PAM8, 1 = NRZ (mapping is identity).
- MSB_FIRST, 1, 1 = first received bit lands in the symbol MSB; 0 = first bit lands in the LSB.
- CNT_W, 32, width of the emitted-symbol counter.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_data  in  1  serial data bit
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle (combinational)
- flush  in  1  pulse: emit the partial symbol, zero-padded
- gray_en  in  1  1 = Gray map, 0 = binary map; quasi-static
- sym_out  out  BITS_PER_SYM  mapped symbol
- sym_valid  out  1  sym_out valid
- sym_ready  in  1  downstream accepts the symbol
- sym_count  out  CNT_W  number of symbols handed off (sym_valid && sym_ready)

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk. Reset values: sym_valid=0, sym_out=0, sym_count=0; internal bit count cnt=0, shift register=0, flush_pend=0. in_ready is 1 in the cycle after reset.
- Handshakes: input and output transfers occur when valid && ready. Define out_free = !sym_valid || sym_ready.
- Assembly: cnt counts 0..BITS_PER_SYM-1 and is $clog2(BITS_PER_SYM+1) bits wide.
  - MSB_FIRST=1: shift left, new bit into the LSB (first bit ends in the MSB).
  - MSB_FIRST=0: the bit is written at index cnt.
- in_ready = !flush && !flush_pend && ((cnt != BITS_PER_SYM-1) || out_free).
  - Backpressure stalls only the symbol-completing bit.
  - Sustained rate is 1 bit/cycle while sym_ready=1.
- Completion: when the last bit is accepted, the assembled word b goes to the output register on that same edge, and cnt returns to 0.
  - sym_out = gray_en ? (b ^ (b >> 1)) : b; gray_en is sampled at that edge.
  - sym_valid rises the next cycle, giving 1-cycle latency from the last accepted bit.
- Output register: sym_out and sym_valid hold stable while sym_valid && !sym_ready. sym_valid clears on handoff unless a new symbol loads on the same edge (back-to-back allowed).
- sym_count increments by 1 on each output handoff and wraps modulo 2^CNT_W.
- Flush:
  - flush=1 sets flush_pend, unless it is serviced the same cycle.
  - Service occurs when flush or flush_pend is set, cnt>0, and out_free. The missing bits are zero-padded: MSB_FIRST=1 left-justifies the received bits; MSB_FIRST=0 leaves the upper bits 0. The result is mapped and loaded exactly like a normal completion, then cnt=0 and flush_pend=0.
  - Flush with cnt==0 is a no-op: it clears flush_pend and emits no symbol.
  - in_data is never accepted during a flush or pending-flush cycle.
- gray_en changes take effect on the next symbol formed. A symbol already held in the output register is not re-mapped.
- Reset mid-operation (mid-symbol or while a symbol is held): the partial symbol and the held output are discarded, and all registers return to their reset values.
- in_valid=0 does not disturb cnt or the shift register (no timeout).

Decomposition:
- Shared package serdes_sym_pkg holds:
  - MAX_BITS_PER_SYM=8
  - bin2gray and gray2bin functions
  - PAM4 level constants shared with the matching Rx demapper
- One sub-module, sym_out_slice: a single-entry valid/ready output register with load, hold and drain. It is reused by the Rx demapper.
- The accumulator, flush logic and counter stay in the top module.

Test Plan:
- Mapping, defaults (BITS_PER_SYM=2, gray_en=1, sym_ready=1): bits 0,0,0,1,1,1,1,0 on consecutive cycles -> symbols 00,01,10,11, each 1 cycle after its 2nd bit; sym_count=4; in_ready stays 1.
- Binary mode (gray_en=0): same stream -> 00,01,11,10.
- Backpressure: hold sym_ready=0 after the first symbol (01) and offer bits 1,1 -> 2nd bit not accepted (in_ready=0) and sym_out holds 01. Raise sym_ready -> in_ready=1 that same cycle, bit accepted, next symbol 10; no bit lost or duplicated.
- Flush (BITS_PER_SYM=3, gray_en=1): bit 1 then flush -> b=100, sym_out=110 one cycle later, sym_count+1. Flush again with cnt=0 -> no sym_valid. Flush while the output is stalled -> pending until sym_ready, then emitted.
- Reset mid-symbol: after 1 bit, pulse rstn=0 for 1 cycle -> sym_valid=0, sym_count=0; next bits 1,1 -> single symbol 10.
- MSB_FIRST=0, BITS_PER_SYM=2, gray_en=1: bits 1,0 -> b=01 -> sym_out 01; bits 0,1 -> b=10 -> sym_out 11.
